// File: rtl/audio_sd_dac.sv
// audio_sd_dac: 1-bit audio output stage for the channel mixer.
// It re-samples the mixer sample once every SAMPLE_DIV clocks. The held sample then ramps
// toward its target, which is 0 when muted, so unmuting and muting do not click. The held
// sample is turned into a bitstream by first-order sigma-delta (MODE=0) or by PWM (MODE=1)
// with a period of 2^WIDTH clocks.
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   enable      run the modulator; low = idle, dac_out forced 0, held sample kept
//   mute        1 = ramp held sample to 0, 0 = ramp to `in`
//   in          unsigned sample from the mixer, looked at only in the tick cycle
//   dac_out     registered bitstream to the RC-filtered pin
//   sample_tick 1-cycle pulse in the cycle whose closing edge updates the held sample
//   busy        1 while the held sample has not yet reached its target
module audio_sd_dac #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned SAMPLE_DIV = 256,
  parameter int unsigned RAMP_STEP  = 16,
  parameter int unsigned MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mute,
  input  logic [WIDTH-1:0] in,
  output logic             dac_out,
  output logic             sample_tick,
  output logic             busy
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
  // A step larger than the full scale behaves the same as a full-scale step.
  localparam int unsigned StepSat = (RAMP_STEP > (32'd1 << WIDTH)) ? (32'd1 << WIDTH) : RAMP_STEP;
  localparam logic [WIDTH:0] Step = (WIDTH+1)'(StepSat);

  logic [DivW-1:0]  div_q, div_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             busy_q, busy_d;
  logic             dac_q;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH:0]   up_diff, dn_diff, up_step, dn_step, ramp_val;

  // Sample-rate divider. A tick is never raised while the block is disabled.
  always_comb begin
    sample_tick = enable && (div_q == DivLast);
    div_d       = '0;
    if (enable && (div_q != DivLast)) begin
      div_d = div_q + 1'b1;
    end
  end

  // Ramp toward the target. The arithmetic is one bit wider than the sample, so the ramp
  // stops exactly at the target and never wraps.
  always_comb begin
    tgt     = mute ? '0 : in;
    up_diff = {1'b0, tgt} - {1'b0, cur_q};
    dn_diff = {1'b0, cur_q} - {1'b0, tgt};
    up_step = (up_diff < Step) ? up_diff : Step;
    dn_step = (dn_diff < Step) ? dn_diff : Step;
    if (RAMP_STEP == 0) begin
      ramp_val = {1'b0, tgt};
    end else if (tgt > cur_q) begin
      ramp_val = {1'b0, cur_q} + up_step;
    end else begin
      ramp_val = {1'b0, cur_q} - dn_step;
    end
    cur_d  = cur_q;
    busy_d = busy_q;
    if (sample_tick) begin
      cur_d  = ramp_val[WIDTH-1:0];
      busy_d = (ramp_val != {1'b0, tgt});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      cur_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cur_q  <= cur_d;
      busy_q <= busy_d;
    end
  end

  if (MODE == 0) begin : g_sd
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   sum;

    // The carry out of the accumulator is the output bit. Its ones density is cur / 2^WIDTH.
    assign sum = {1'b0, acc_q} + {1'b0, cur_q};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_q <= '0;
        dac_q <= 1'b0;
      end else if (!enable) begin
        acc_q <= '0;
        dac_q <= 1'b0;
      end else begin
        acc_q <= sum[WIDTH-1:0];
        dac_q <= sum[WIDTH];
      end
    end
  end else begin : g_pwm
    logic [WIDTH-1:0] pwm_cnt_q;
    logic [WIDTH-1:0] pwm_ref_q;

    // The duty reference is reloaded only at the period boundary, so a sample that
    // changes mid-period never produces a runt pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pwm_cnt_q <= '0;
        pwm_ref_q <= '0;
        dac_q     <= 1'b0;
      end else if (!enable) begin
        pwm_cnt_q <= '0;
        dac_q     <= 1'b0;
      end else begin
        pwm_cnt_q <= pwm_cnt_q + 1'b1;
        if (pwm_cnt_q == '0) begin
          pwm_ref_q <= cur_q;
        end
        dac_q <= (pwm_cnt_q < pwm_ref_q);
      end
    end
  end

  assign dac_out = dac_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Testbench for audio_sd_dac. It builds three instances that share one set of inputs:
//   0: ramping sigma-delta (RAMP_STEP=16, MODE=0)
//   1: step-jump sigma-delta (RAMP_STEP=0, MODE=0)
//   2: step-jump PWM (RAMP_STEP=0, MODE=1)
// A behavioural model predicts every output and every held sample on every clock.
// Directed sequences and a vector table cover the corner cases.
module tb_audio_sd_dac;
  localparam int W   = 12;
  localparam int DIV = 8;
  localparam int PER = 4096;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic mute = 1'b0;
  logic [W-1:0] din = '0;
  logic [2:0] dac_v, tick_v, busy_v;
  logic [W-1:0] cur_v [3];

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  audio_sd_dac #(.WIDTH(W), .SAMPLE_DIV(DIV), .RAMP_STEP(16), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mute(mute), .in(din),
    .dac_out(dac_v[0]), .sample_tick(tick_v[0]), .busy(busy_v[0]));
  audio_sd_dac #(.WIDTH(W), .SAMPLE_DIV(DIV), .RAMP_STEP(0), .MODE(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mute(mute), .in(din),
    .dac_out(dac_v[1]), .sample_tick(tick_v[1]), .busy(busy_v[1]));
  audio_sd_dac #(.WIDTH(W), .SAMPLE_DIV(DIV), .RAMP_STEP(0), .MODE(1)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .mute(mute), .in(din),
    .dac_out(dac_v[2]), .sample_tick(tick_v[2]), .busy(busy_v[2]));

  assign cur_v[0] = dut_a.cur_q;
  assign cur_v[1] = dut_b.cur_q;
  assign cur_v[2] = dut_c.cur_q;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model, built directly from the rules of the block.
  int step_tab [3] = '{16, 0, 0};
  int mode_tab [3] = '{0, 0, 1};
  int m_div [3], m_cur [3], m_busy [3], m_acc [3], m_pcnt [3], m_pref [3], m_dac [3];

  initial begin
    int tgt, nc, old, s;
    forever begin
      @(posedge clk or posedge reset);
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          m_div[i] = 0; m_cur[i] = 0; m_busy[i] = 0; m_acc[i] = 0;
          m_pcnt[i] = 0; m_pref[i] = 0; m_dac[i] = 0;
        end else if (!enable) begin
          m_div[i] = 0; m_acc[i] = 0; m_pcnt[i] = 0; m_dac[i] = 0;
        end else begin
          old = m_cur[i];
          if (m_div[i] == DIV - 1) begin
            tgt = mute ? 0 : int'(din);
            if (step_tab[i] == 0) nc = tgt;
            else if (tgt > old) nc = old + ((tgt - old < step_tab[i]) ? tgt - old : step_tab[i]);
            else nc = old - ((old - tgt < step_tab[i]) ? old - tgt : step_tab[i]);
            m_cur[i]  = nc;
            m_busy[i] = (nc != tgt) ? 1 : 0;
          end
          m_div[i] = (m_div[i] + 1) % DIV;
          if (mode_tab[i] == 0) begin
            s = m_acc[i] + old;
            m_dac[i] = s / PER;
            m_acc[i] = s % PER;
          end else begin
            m_dac[i] = (m_pcnt[i] < m_pref[i]) ? 1 : 0;
            if (m_pcnt[i] == 0) m_pref[i] = old;
            m_pcnt[i] = (m_pcnt[i] + 1) % PER;
          end
        end
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (run_chk && !reset) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cyc_dac%0d", i), {31'b0, dac_v[i]}, m_dac[i]);
        check($sformatf("cyc_tick%0d", i), {31'b0, tick_v[i]},
              (enable && m_div[i] == DIV - 1) ? 1 : 0);
        check($sformatf("cyc_busy%0d", i), {31'b0, busy_v[i]}, m_busy[i]);
        check($sformatf("cyc_cur%0d", i), {20'b0, cur_v[i]}, m_cur[i]);
      end
    end
  end

  // Returns at the negedge of a tick cycle.
  task automatic wait_tick_neg();
    bit seen = 1'b0;
    for (int n = 0; n < 4 * DIV && !seen; n++) begin
      @(negedge clk);
      seen = tick_v[0];
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  // Returns just after the edge that closes a tick cycle.
  task automatic wait_tick();
    wait_tick_neg();
    @(posedge clk); #1;
  endtask

  task automatic wait_pcnt(input int val);
    bit seen = 1'b0;
    for (int n = 0; n < 2 * PER && !seen; n++) begin
      @(negedge clk);
      seen = (m_pcnt[2] == val);
    end
    if (!seen) check("pcnt_timeout", 0, 1);
  endtask

  typedef struct {
    logic         mute;
    logic [W-1:0] din;
    int           exp_cur;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int cnt;
    vecs[0] = '{1'b0, 12'h123, 'h123};
    vecs[1] = '{1'b1, 12'hFFF, 0};
    vecs[2] = '{1'b0, 12'hFFF, 'hFFF};
    vecs[3] = '{1'b0, 12'h000, 0};
    vecs[4] = '{1'b0, 12'h800, 'h800};
    vecs[5] = '{1'b1, 12'h001, 0};
    vecs[6] = '{1'b0, 12'h001, 1};
    vecs[7] = '{1'b0, 12'hABC, 'hABC};

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_dac%0d", i), {31'b0, dac_v[i]}, 0);
      check($sformatf("rst_tick%0d", i), {31'b0, tick_v[i]}, 0);
      check($sformatf("rst_busy%0d", i), {31'b0, busy_v[i]}, 0);
      check($sformatf("rst_cur%0d", i), {20'b0, cur_v[i]}, 0);
    end
    @(negedge clk); #2 reset = 1'b0;
    run_chk = 1'b1;

    // T3: ramp up by 16 per tick, then mute and ramp back down.
    @(posedge clk); #1;
    enable = 1'b1; din = 12'h100; mute = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick();
      check("t3_up_cur", {20'b0, cur_v[0]}, 16 * k);
      check("t3_up_busy", {31'b0, busy_v[0]}, (k < 16) ? 1 : 0);
    end
    mute = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wait_tick();
      check("t3_dn_cur", {20'b0, cur_v[0]}, 256 - 16 * k);
      check("t3_dn_busy", {31'b0, busy_v[0]}, (k < 16) ? 1 : 0);
    end

    // T5: drop enable at cur=0x40, then re-enable.
    mute = 1'b0;
    repeat (4) wait_tick();
    check("t5_cur40", {20'b0, cur_v[0]}, 'h40);
    enable = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick_v[0]) cnt++;
    end
    check("t5_no_ticks", cnt, 0);
    check("t5_dac_low", {31'b0, dac_v[0]}, 0);
    check("t5_cur_hold", {20'b0, cur_v[0]}, 'h40);
    check("t5_busy_hold", {31'b0, busy_v[0]}, 1);
    @(posedge clk); #1 enable = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 4 * DIV && cnt == 0; n++) begin
      @(negedge clk);
      if (tick_v[0]) cnt = n;
    end
    check("t5_first_tick", cnt, DIV);
    @(posedge clk); #1;
    check("t5_resume", {20'b0, cur_v[0]}, 'h50);

    // T1: reset in the middle of a ramp, on the 10th tick.
    din = 12'h800;
    repeat (9) wait_tick();
    wait_tick_neg();
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_dac%0d", i), {31'b0, dac_v[i]}, 0);
      check($sformatf("t1_tick%0d", i), {31'b0, tick_v[i]}, 0);
      check($sformatf("t1_busy%0d", i), {31'b0, busy_v[i]}, 0);
      check($sformatf("t1_cur%0d", i), {20'b0, cur_v[i]}, 0);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // Vector table on the step-jump instance.
    wait_tick();
    foreach (vecs[v]) begin
      mute = vecs[v].mute;
      din  = vecs[v].din;
      wait_tick();
      check($sformatf("vec%0d_cur", v), {20'b0, cur_v[1]}, vecs[v].exp_cur);
      check($sformatf("vec%0d_busy", v), {31'b0, busy_v[1]}, 0);
    end

    // T6: the input toggles between ticks; only the value held in the tick cycle counts.
    mute = 1'b0;
    for (int j = 0; j < DIV - 1; j++) begin
      din = (j % 2 != 0) ? 12'hFFF : 12'h000;
      @(posedge clk); #1;
    end
    din = 12'h123;
    wait_tick();
    din = 12'hFFF;
    check("t6_cur", {20'b0, cur_v[1]}, 'h123);

    // Random stimulus, including single-cycle enable drops that can coincide with a tick.
    repeat (1500) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) din = W'($urandom);
      mute   = ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 39) != 0);
    end
    @(posedge clk); #1;
    enable = 1'b1; mute = 1'b0;

    // T2: sigma-delta with a constant 0x400 gives 2048 ones in 8192 clocks.
    din = 12'h400;
    wait_tick();
    @(posedge clk); #1;
    cnt = 0;
    repeat (8192) begin
      @(negedge clk);
      if (dac_v[1]) cnt++;
    end
    check("t2_ones_in_range", (cnt >= 2047 && cnt <= 2049) ? 1 : 0, 1);

    // T4: PWM at 0xFFF is high for 4095 of 4096 clocks. A change in mid-period waits for
    // the next boundary.
    din = 12'hFFF;
    wait_tick();
    wait_pcnt(1);
    wait_pcnt(1);
    cnt = 0;
    repeat (PER) begin
      if (dac_v[2]) cnt++;
      @(negedge clk);
    end
    check("t4_full_ones", cnt, PER - 1);
    wait_pcnt(2048);
    @(posedge clk); #1 din = 12'h000;
    wait_tick();
    check("t4_cur_zero", {20'b0, cur_v[2]}, 0);
    @(negedge clk);
    check("t4_still_high", {31'b0, dac_v[2]}, 1);
    wait_pcnt(2);
    cnt = 0;
    repeat (PER) begin
      if (dac_v[2]) cnt++;
      @(negedge clk);
    end
    check("t4_zero_ones", cnt, 0);

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
